// File: rtl/int_seq_pkg.sv
// Shared types and constants for the interrupt sequencer: FSM state encoding,
// CCR width, default vector location and the order of the three stack pushes.
package int_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLUSH   = 3'd1,
    S_PUSH_HI = 3'd2,
    S_PUSH_LO = 3'd3,
    S_PUSH_FL = 3'd4,
    S_RD_HI   = 3'd5,
    S_RD_LO   = 3'd6,
    S_JUMP    = 3'd7
  } state_t;

  localparam int unsigned FLAG_WIDTH          = 3;
  localparam int unsigned VECTOR_ADDR_DEFAULT = 0;

  localparam logic [1:0] PUSH_SLOT_HI   = 2'd0;
  localparam logic [1:0] PUSH_SLOT_LO   = 2'd1;
  localparam logic [1:0] PUSH_SLOT_FL   = 2'd2;
  localparam logic [1:0] PUSH_SLOT_NONE = 2'd3;

  function automatic logic [1:0] push_slot(input state_t s);
    case (s)
      S_PUSH_HI: push_slot = PUSH_SLOT_HI;
      S_PUSH_LO: push_slot = PUSH_SLOT_LO;
      S_PUSH_FL: push_slot = PUSH_SLOT_FL;
      default:   push_slot = PUSH_SLOT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/int_edge_latch.sv
// Rising-edge capture of the interrupt request into a pending flag, with a
// sticky flag recording any edge that arrived while one was already pending.
module int_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  input  logic clear_i,
  output logic edge_o,
  output logic pending_o,
  output logic missed_o
);

  logic prev_q, prev_d;
  logic pending_q, pending_d;
  logic missed_q, missed_d;

  always_comb begin
    edge_o    = req_i & ~prev_q;
    prev_d    = req_i;
    // A new edge beats a clear issued in the same cycle.
    pending_d = edge_o | (pending_q & ~clear_i);
    missed_d  = missed_q | (edge_o & pending_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q    <= 1'b0;
      pending_q <= 1'b0;
      missed_q  <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      pending_q <= pending_d;
      missed_q  <= missed_d;
    end
  end

  assign pending_o = pending_q;
  assign missed_o  = missed_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: waits for a safe pipeline point, flushes, pushes
// return PC and flags through the shared data port, then loads the ISR vector.
module interrupt_sequencer #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FLAG_WIDTH  = int_seq_pkg::FLAG_WIDTH,
  parameter int unsigned VECTOR_ADDR = int_seq_pkg::VECTOR_ADDR_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  interupt,
  input  logic                  pipe_stall,
  input  logic                  branch_busy,
  input  logic [PC_WIDTH-1:0]   ret_pc,
  input  logic [FLAG_WIDTH-1:0] flags_in,
  input  logic                  mem_gnt,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  mem_use_sp,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  sp_dec,
  output logic                  flush,
  output logic                  freeze_fetch,
  output logic                  pc_load,
  output logic [PC_WIDTH-1:0]   pc_load_val,
  output logic                  busy,
  output logic                  int_missed
);

  import int_seq_pkg::*;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   ret_q, ret_d;
  logic [FLAG_WIDTH-1:0] flags_q, flags_d;
  logic [DATA_WIDTH-1:0] vec_hi_q, vec_hi_d;
  logic [DATA_WIDTH-1:0] vec_lo_q, vec_lo_d;

  logic req_edge;
  logic pending;
  logic clear_pending;

  assign clear_pending = (state_q == S_FLUSH);

  int_edge_latch u_edge (
    .clk       (clk),
    .reset     (reset),
    .req_i     (interupt),
    .clear_i   (clear_pending),
    .edge_o    (req_edge),
    .pending_o (pending),
    .missed_o  (int_missed)
  );

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    flags_d  = flags_q;
    vec_hi_d = vec_hi_q;
    vec_lo_d = vec_lo_q;

    unique case (state_q)
      // The edge itself counts as pending so FLUSH follows the capture cycle.
      S_IDLE: if ((pending | req_edge) & ~pipe_stall & ~branch_busy) state_d = S_FLUSH;
      S_FLUSH: begin
        ret_d   = ret_pc;
        flags_d = flags_in;
        state_d = S_PUSH_HI;
      end
      S_PUSH_HI: if (mem_gnt) state_d = S_PUSH_LO;
      S_PUSH_LO: if (mem_gnt) state_d = S_PUSH_FL;
      S_PUSH_FL: if (mem_gnt) state_d = S_RD_HI;
      S_RD_HI: if (mem_gnt) begin
        vec_hi_d = mem_rdata;
        state_d  = S_RD_LO;
      end
      S_RD_LO: if (mem_gnt) begin
        vec_lo_d = mem_rdata;
        state_d  = S_JUMP;
      end
      S_JUMP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_use_sp   = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    sp_dec       = 1'b0;
    flush        = (state_q == S_FLUSH);
    freeze_fetch = (state_q != S_IDLE);
    busy         = (state_q != S_IDLE);
    pc_load      = 1'b0;
    pc_load_val  = '0;

    case (push_slot(state_q))
      PUSH_SLOT_HI: mem_wdata = ret_q[PC_WIDTH-1 -: DATA_WIDTH];
      PUSH_SLOT_LO: mem_wdata = ret_q[DATA_WIDTH-1:0];
      PUSH_SLOT_FL: mem_wdata = DATA_WIDTH'(flags_q);
      default:      mem_wdata = '0;
    endcase

    if (push_slot(state_q) != PUSH_SLOT_NONE) begin
      mem_req    = 1'b1;
      mem_we     = 1'b1;
      mem_use_sp = 1'b1;
      sp_dec     = mem_gnt;
    end

    if (state_q == S_RD_HI) begin
      mem_req  = 1'b1;
      mem_addr = DATA_WIDTH'(VECTOR_ADDR);
    end
    if (state_q == S_RD_LO) begin
      mem_req  = 1'b1;
      mem_addr = DATA_WIDTH'(VECTOR_ADDR + 1);
    end

    if (state_q == S_JUMP) begin
      pc_load     = 1'b1;
      pc_load_val = PC_WIDTH'({vec_hi_q, vec_lo_q});
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ret_q    <= '0;
      flags_q  <= '0;
      vec_hi_q <= '0;
      vec_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      flags_q  <= flags_d;
      vec_hi_q <= vec_hi_d;
      vec_lo_q <= vec_lo_d;
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench: a step-table model of the trap sequence checked every
// cycle, plus literal checks of latency, push contents and sticky flags.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        interupt = 1'b0;
  logic        pipe_stall = 1'b0;
  logic        branch_busy = 1'b0;
  logic [31:0] ret_pc = '0;
  logic [2:0]  flags_in = '0;
  logic        mem_gnt = 1'b1;
  logic [15:0] mem_rdata;
  logic        mem_req, mem_we, mem_use_sp, sp_dec, flush, freeze_fetch;
  logic        pc_load, busy, int_missed;
  logic [15:0] mem_addr, mem_wdata;
  logic [31:0] pc_load_val;

  interrupt_sequencer #(.PC_WIDTH(32), .DATA_WIDTH(16), .FLAG_WIDTH(3), .VECTOR_ADDR(0)) dut (
    .clk(clk), .reset(reset), .interupt(interupt), .pipe_stall(pipe_stall),
    .branch_busy(branch_busy), .ret_pc(ret_pc), .flags_in(flags_in),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_use_sp(mem_use_sp), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .sp_dec(sp_dec), .flush(flush), .freeze_fetch(freeze_fetch), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .busy(busy), .int_missed(int_missed)
  );

  always #5 clk = ~clk;

  localparam int VA = 0;
  logic [15:0] vec_mem [2];
  initial begin
    vec_mem[0] = 16'h0000;
    vec_mem[1] = 16'h0200;
  end

  always_comb begin
    mem_rdata = 16'hBEEF;
    if (mem_req && !mem_we) begin
      if (int'(mem_addr) == VA)          mem_rdata = vec_mem[0];
      else if (int'(mem_addr) == VA + 1) mem_rdata = vec_mem[1];
    end
  end

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observations of the DUT, used by the literal checks in the stimulus.
  int          seq_cnt = 0;
  int          sp_cnt = 0;
  int          last_lat = -1;
  int          edge_cyc = 0;
  logic [15:0] push_q [$];

  // Model: step 0 idle, 1 flush, 2..4 pushes, 5..6 vector reads, 7 jump.
  int          step_m = 0;
  logic        prev_m = 1'b0, pend_m = 1'b0, miss_m = 1'b0;
  logic [15:0] words_m [3];
  logic [15:0] vec_m [2];

  always begin : model
    int          n_step;
    logic        n_prev, n_pend, n_miss, edge_m;
    logic        e_req, e_we, e_sp, e_spd, e_fl, e_fz, e_pcl, e_busy;
    logic [15:0] e_addr, e_wdata;
    logic [31:0] e_pcv;
    logic [15:0] n_words [3];
    logic [15:0] n_vec [2];
    @(negedge clk);
    e_req = 0; e_we = 0; e_sp = 0; e_spd = 0; e_fl = 0; e_fz = 0; e_pcl = 0; e_busy = 0;
    e_addr = '0; e_wdata = '0; e_pcv = '0;
    n_words = words_m; n_vec = vec_m;
    if (reset) begin
      n_step = 0; n_prev = 0; n_pend = 0; n_miss = 0; edge_m = 0;
    end else begin
      edge_m = interupt & ~prev_m;
      if (edge_m) edge_cyc = cyc;
      n_prev = interupt;
      n_pend = pend_m | edge_m;
      n_miss = miss_m | (edge_m & pend_m);
      n_step = step_m;
      e_busy = (step_m != 0);
      e_fz   = (step_m != 0);
      if (step_m == 0) begin
        if ((pend_m || edge_m) && !pipe_stall && !branch_busy) n_step = 1;
      end else if (step_m == 1) begin
        e_fl = 1;
        n_pend = edge_m;
        n_words[0] = ret_pc[31:16];
        n_words[1] = ret_pc[15:0];
        n_words[2] = {13'd0, flags_in};
        n_step = 2;
      end else if (step_m <= 4) begin
        e_req = 1; e_we = 1; e_sp = 1;
        e_wdata = words_m[step_m-2];
        e_spd = mem_gnt;
        if (mem_gnt) n_step = step_m + 1;
      end else if (step_m <= 6) begin
        e_req = 1;
        e_addr = 16'(VA + step_m - 5);
        if (mem_gnt) begin
          n_vec[step_m-5] = vec_mem[step_m-5];
          n_step = step_m + 1;
        end
      end else begin
        e_pcl = 1;
        e_pcv = {vec_m[0], vec_m[1]};
        n_step = 0;
      end
    end

    chk("busy", busy, e_busy);
    chk("freeze_fetch", freeze_fetch, e_fz);
    chk("flush", flush, e_fl);
    chk("mem_req", mem_req, e_req);
    chk("sp_dec", sp_dec, e_spd);
    chk("pc_load", pc_load, e_pcl);
    chk("int_missed", int_missed, reset ? 1'b0 : miss_m);
    if (e_req || step_m == 0 || reset) chk("mem_we", mem_we, e_we);
    if (e_req || reset) chk("mem_use_sp", mem_use_sp, e_sp);
    if (!e_req || e_we) chk("mem_wdata", mem_wdata, e_wdata);
    if (!e_req || !e_we) chk("mem_addr", mem_addr, e_addr);
    if (e_pcl) chk("pc_load_val", pc_load_val, e_pcv);

    if (pc_load) begin
      seq_cnt++;
      last_lat = cyc - edge_cyc;
    end
    if (sp_dec) sp_cnt++;
    if (mem_req && mem_we && mem_gnt) push_q.push_back(mem_wdata);

    @(posedge clk);
    step_m = n_step; prev_m = n_prev; pend_m = n_pend; miss_m = n_miss;
    words_m = n_words; vec_m = n_vec;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_obs();
    seq_cnt = 0;
    sp_cnt = 0;
    last_lat = -1;
    push_q.delete();
  endtask

  initial begin
    #2;
    chk("reset_busy", busy, 1'b0);
    chk("reset_req", mem_req, 1'b0);
    chk("reset_pcl", pc_load, 1'b0);
    chk("reset_missed", int_missed, 1'b0);
    tick(2);
    reset = 0;
    tick(2);

    // Clean entry
    ret_pc = 32'h0000_0123; flags_in = 3'b101; mem_gnt = 1;
    clear_obs();
    interupt = 1; tick(1); interupt = 0; tick(11);
    chk("clean_lat", 32'(last_lat), 32'd7);
    chk("clean_seq", 32'(seq_cnt), 32'd1);
    chk("clean_spdec", 32'(sp_cnt), 32'd3);
    chk("clean_push0", push_q[0], 16'h0000);
    chk("clean_push1", push_q[1], 16'h0123);
    chk("clean_push2", push_q[2], 16'h0005);
    chk("clean_npush", 32'(push_q.size()), 32'd3);

    // Stall gate
    ret_pc = 32'h1234_5678; flags_in = 3'b010;
    clear_obs();
    pipe_stall = 1; interupt = 1; tick(1); interupt = 0; tick(3); pipe_stall = 0; tick(12);
    chk("stall_lat", 32'(last_lat), 32'd11);
    chk("stall_push0", push_q[0], 16'h1234);
    chk("stall_push1", push_q[1], 16'h5678);
    chk("stall_push2", push_q[2], 16'h0002);

    // Grant starvation during PUSH_LO
    ret_pc = 32'h0000_0123; flags_in = 3'b101;
    clear_obs();
    interupt = 1; tick(1); interupt = 0; tick(2);
    mem_gnt = 0; tick(1);
    @(negedge clk);
    chk("starve_wdata", mem_wdata, 16'h0123);
    chk("starve_spdec", sp_dec, 1'b0);
    chk("starve_sp_cnt", 32'(sp_cnt), 32'd1);
    tick(2);
    mem_gnt = 1; tick(10);
    chk("starve_lat", 32'(last_lat), 32'd10);
    chk("starve_spdec_total", 32'(sp_cnt), 32'd3);

    // Back-to-back: second edge during RD_HI is serviced, not lost
    clear_obs();
    interupt = 1; tick(1); interupt = 0; tick(4);
    interupt = 1; tick(1); interupt = 0; tick(20);
    chk("b2b_seq", 32'(seq_cnt), 32'd2);
    chk("b2b_missed", int_missed, 1'b0);

    // Third edge while pending is set
    clear_obs();
    interupt = 1; tick(1); interupt = 0; tick(4);
    interupt = 1; tick(1); interupt = 0; tick(1);
    interupt = 1; tick(1); interupt = 0; tick(20);
    chk("miss_flag", int_missed, 1'b1);
    chk("miss_seq", 32'(seq_cnt), 32'd2);
    reset = 1; #1;
    chk("miss_cleared", int_missed, 1'b0);
    tick(2);
    reset = 0; tick(2);

    // Reset mid-sequence
    clear_obs();
    interupt = 1; tick(1); interupt = 0; tick(2);
    chk("midop_busy_before", busy, 1'b1);
    reset = 1; #1;
    chk("midop_busy", busy, 1'b0);
    chk("midop_req", mem_req, 1'b0);
    chk("midop_wdata", mem_wdata, 16'h0000);
    chk("midop_freeze", freeze_fetch, 1'b0);
    tick(2);
    reset = 0; tick(10);
    chk("midop_no_pcl", 32'(seq_cnt), 32'd0);
    chk("midop_idle", busy, 1'b0);

    // Level hold with branch gate
    clear_obs();
    branch_busy = 1; interupt = 1; tick(2); branch_busy = 0; tick(18);
    interupt = 0; tick(10);
    chk("level_seq", 32'(seq_cnt), 32'd1);
    chk("level_lat", 32'(last_lat), 32'd9);
    chk("level_spdec", 32'(sp_cnt), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
